// File: rtl/threshold_stream_ctrl_if.sv
// threshold_stream_ctrl_if: upstream pixel stream and thresholded output stream of the controller
interface threshold_stream_ctrl_if;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] out_pix;
  logic       out_valid;
  logic       out_last;
  modport master(output pix_in, pix_valid, input pix_ready, out_pix, out_valid, out_last);
  modport slave(input pix_in, pix_valid, output pix_ready, out_pix, out_valid, out_last);
endinterface

// File: rtl/threshold_stream_ctrl.sv
// threshold_stream_ctrl: buffers pixels, sequences threshold loads between frames and re-aligns the unit's result
module threshold_stream_ctrl #(
  parameter int FRAME_PIXELS = 4096,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           thr_in,
  input  logic                 thr_we,
  threshold_stream_ctrl_if.slave s,
  output logic                 th_mode,
  output logic [7:0]           th_byte,
  input  logic [7:0]           th_result,
  output logic                 frame_busy,
  output logic [CNT_W-1:0]     fg_count,
  output logic                 fg_count_valid
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(FRAME_PIXELS);
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;
  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW:0]      wp, rp;
  logic [7:0]       thr_pend;
  logic             pend, thr_loaded, drain;
  logic             tag, tag_last, tag_d, last_d;
  logic [PW-1:0]    pix_cnt;
  logic [CNT_W-1:0] fg_acc;
  logic             empty, full, push, pop, pix_last, frame_end;
  assign empty      = wp == rp;
  assign full       = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign push       = s.pix_valid && !full;
  assign pop        = (state == STREAM) && !empty;
  assign pix_last   = pix_cnt == PW'(FRAME_PIXELS - 1);
  assign frame_end  = s.out_valid && s.out_last;
  assign s.pix_ready = !full;
  assign frame_busy = state != IDLE;
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= s.pix_in;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      thr_pend <= '0;
      pend <= 1'b0;
      thr_loaded <= 1'b0;
      drain <= 1'b0;
      th_mode <= 1'b0;
      th_byte <= '0;
      tag <= 1'b0;
      tag_last <= 1'b0;
      tag_d <= 1'b0;
      last_d <= 1'b0;
      pix_cnt <= '0;
      s.out_pix <= '0;
      s.out_valid <= 1'b0;
      s.out_last <= 1'b0;
      fg_acc <= '0;
      fg_count <= '0;
      fg_count_valid <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      // a write landing in the LOAD cycle keeps pend set so a second LOAD follows
      if (thr_we) begin
        thr_pend <= thr_in;
        pend <= 1'b1;
      end else if (state == LOAD) pend <= 1'b0;
      tag <= pop;
      tag_last <= pop && pix_last;
      tag_d <= tag;
      last_d <= tag_last;
      s.out_valid <= tag_d;
      s.out_last <= last_d;
      s.out_pix <= tag_d ? th_result : 8'h00;
      if (frame_end) fg_acc <= '0;
      else if (tag_d && th_result != 8'h00 && fg_acc != '1) fg_acc <= fg_acc + 1'b1;
      fg_count_valid <= frame_end;
      if (frame_end) fg_count <= fg_acc;
      case (state)
        IDLE:
          if (pend) begin
            state <= LOAD;
            th_mode <= 1'b1;
            th_byte <= thr_we ? thr_in : thr_pend;
          end else if (thr_loaded && !empty) state <= STREAM;
        LOAD: begin
          th_mode <= 1'b0;
          thr_loaded <= 1'b1;
          state <= IDLE;
        end
        STREAM:
          if (pop) begin
            th_byte <= mem[rp[AW-1:0]];
            pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
            if (pix_last) state <= DRAIN;
          end
        default: begin
          drain <= !drain;
          if (drain) state <= IDLE;
        end
      endcase
    end
endmodule
